ir_encoder: RTL and testbench

IR_ENCODER -- requirements
Module: ir_encoder

---
 rtl/ir_encoder.sv | 162 ++++++++++++++++
 tb/tb_ir_encoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ir_encoder.sv
// NEC-style IR message encoder: start burst/space, MSB-first bit
// bursts with width-coded spaces, stop burst, then a mandatory gap.
module ir_encoder #(
  parameter int MESSAGE_LENGTH = 5,
  parameter int CARRIER_PERIOD = 2632,
  parameter int START_HIGH     = 900000,
  parameter int START_LOW      = 450000,
  parameter int BIT_HIGH       = 56000,
  parameter int ZERO_LOW       = 56000,
  parameter int ONE_LOW        = 169000,
  parameter int GAP            = 1000000
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [MESSAGE_LENGTH-1:0] data_in,
  input  logic                      data_valid_in,
  output logic                      ready_out,
  output logic                      envelope_out,
  output logic                      signal_out,
  output logic                      busy_out,
  output logic                      done_out
);

  localparam int M0 = START_HIGH > START_LOW ? START_HIGH : START_LOW;
  localparam int M1 = BIT_HIGH > ZERO_LOW ? BIT_HIGH : ZERO_LOW;
  localparam int M2 = ONE_LOW > GAP ? ONE_LOW : GAP;
  localparam int M3 = M0 > M1 ? M0 : M1;
  localparam int MAX_T = M3 > M2 ? M3 : M2;
  localparam int CW = $clog2(MAX_T + 1);
  localparam int PW = $clog2(CARRIER_PERIOD);
  localparam int BW = $clog2(MESSAGE_LENGTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_BURST,
    ST_START_SPACE,
    ST_BIT_BURST,
    ST_BIT_SPACE,
    ST_STOP_BURST,
    ST_GAP
  } state_t;

  state_t                    state;
  state_t                    state_nx;
  logic [CW-1:0]             cnt;
  logic [CW-1:0]             dur;
  logic                      last;
  logic [PW-1:0]             phase;
  logic [BW-1:0]             bit_cnt;
  logic [MESSAGE_LENGTH-1:0] shreg;
  logic                      env_q;
  logic                      env_nx;
  logic                      in_idle;

  always_comb begin
    dur = '0;
    unique case (state)
      ST_START_BURST: dur = CW'(START_HIGH);
      ST_START_SPACE: dur = CW'(START_LOW);
      ST_BIT_BURST:   dur = CW'(BIT_HIGH);
      ST_BIT_SPACE:   dur = shreg[MESSAGE_LENGTH-1] ?
                            CW'(ONE_LOW) : CW'(ZERO_LOW);
      ST_STOP_BURST:  dur = CW'(BIT_HIGH);
      ST_GAP:         dur = CW'(GAP);
      default:        dur = '0;
    endcase
  end

  assign last = (cnt == dur - CW'(1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (data_valid_in) state_nx = ST_START_BURST;
      ST_START_BURST:
        if (last) state_nx = ST_START_SPACE;
      ST_START_SPACE:
        if (last) state_nx = ST_BIT_BURST;
      ST_BIT_BURST:
        if (last) state_nx = ST_BIT_SPACE;
      ST_BIT_SPACE:
        if (last) begin
          if (bit_cnt == BW'(MESSAGE_LENGTH - 1))
            state_nx = ST_STOP_BURST;
          else
            state_nx = ST_BIT_BURST;
        end
      ST_STOP_BURST:
        if (last) state_nx = ST_GAP;
      ST_GAP:
        if (last) state_nx = ST_IDLE;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_idle  = 1'b0;
    env_nx   = 1'b0;
    done_out = 1'b0;
    unique case (1'b1)
      state == ST_GAP: done_out = last;
      default:         in_idle  = (state == ST_IDLE);
    endcase
    unique case (1'b1)
      state_nx == ST_START_BURST: env_nx = 1'b1;
      state_nx == ST_BIT_BURST:   env_nx = 1'b1;
      state_nx == ST_STOP_BURST:  env_nx = 1'b1;
      default:                    env_nx = 1'b0;
    endcase
  end

  // Duration and carrier phase both restart on every state change,
  // so each burst begins with a full carrier high half.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt   <= '0;
      phase <= '0;
      env_q <= 1'b0;
    end else begin
      env_q <= env_nx;
      if (state_nx != state || state_nx == ST_IDLE) begin
        cnt   <= '0;
        phase <= '0;
      end else begin
        cnt <= cnt + CW'(1);
        if (phase == PW'(CARRIER_PERIOD - 1))
          phase <= '0;
        else
          phase <= phase + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (in_idle && data_valid_in) begin
      shreg   <= data_in;
      bit_cnt <= '0;
    end else if (state == ST_BIT_SPACE && last) begin
      shreg   <= {shreg[MESSAGE_LENGTH-2:0], 1'b0};
      bit_cnt <= bit_cnt + BW'(1);
    end
  end

  assign ready_out    = rst_in & in_idle;
  assign busy_out     = (state != ST_IDLE);
  assign envelope_out = env_q;
  assign signal_out   = env_q & (phase < PW'(CARRIER_PERIOD / 2));

endmodule

// File: tb/tb_ir_encoder.sv
// Scoreboard bench for ir_encoder: the monitor demodulates the
// envelope back into run lengths and a payload code per message.
module tb_ir_encoder;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic [4:0] data_in = '0;
  logic       data_valid_in = 1'b0;
  logic       ready_out;
  logic       envelope_out;
  logic       signal_out;
  logic       busy_out;
  logic       done_out;

  int checks = 0;
  int failures = 0;
  int sig_err = 0;

  logic [4:0] exp_q[$];
  int highs[$];
  int lows[$];
  int run = 0;
  int busy_cnt = 0;
  int car_err = 0;
  logic prev_env = 1'b0;
  bit in_msg = 1'b0;

  ir_encoder #(
    .MESSAGE_LENGTH(5),
    .CARRIER_PERIOD(4),
    .START_HIGH(40),
    .START_LOW(20),
    .BIT_HIGH(8),
    .ZERO_LOW(8),
    .ONE_LOW(24),
    .GAP(16)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .data_in(data_in),
    .data_valid_in(data_valid_in),
    .ready_out(ready_out),
    .envelope_out(envelope_out),
    .signal_out(signal_out),
    .busy_out(busy_out),
    .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int exp_busy(input logic [4:0] c);
    int t;
    t = 40 + 20 + 8 + 16;
    for (int i = 0; i < 5; i++)
      t += 8 + (c[i] ? 24 : 8);
    return t;
  endfunction

  task automatic end_msg();
    logic [4:0] exp;
    logic [4:0] got;
    int bad;
    if (exp_q.size() == 0) begin
      chk("unexpected_done", 1, 0);
      return;
    end
    exp = exp_q.pop_front();
    chk("high_runs", highs.size(), 7);
    chk("low_runs", lows.size(), 6);
    if (highs.size() == 7 && lows.size() == 6) begin
      chk("start_high", highs[0], 40);
      chk("start_low", lows[0], 20);
      chk("stop_high", highs[6], 8);
      bad = 0;
      got = '0;
      for (int i = 0; i < 5; i++) begin
        if (highs[i+1] != 8) bad++;
        if (lows[i+1] != 8 && lows[i+1] != 24) bad++;
        got = {got[3:0], lows[i+1] == 24};
      end
      chk("bit_runs_bad", bad, 0);
      chk("decoded_code", int'(got), int'(exp));
    end
    chk("busy_cycles", busy_cnt, exp_busy(exp));
    chk("carrier_err", car_err, 0);
  endtask

  always @(negedge clk_in) begin
    if (!rst_in) begin
      in_msg = 1'b0;
    end else begin
      if (!envelope_out && signal_out) sig_err++;
      if (busy_out && !in_msg) begin
        in_msg = 1'b1;
        highs.delete();
        lows.delete();
        run = 1;
        busy_cnt = 1;
        car_err = 0;
        prev_env = envelope_out;
      end else if (busy_out) begin
        busy_cnt++;
        if (envelope_out == prev_env) begin
          run++;
        end else begin
          if (prev_env) highs.push_back(run);
          else lows.push_back(run);
          run = 1;
          prev_env = envelope_out;
        end
      end
      if (busy_out && envelope_out &&
          signal_out !== (((run - 1) % 4) < 2))
        car_err++;
      if (done_out) begin
        if (!in_msg) chk("done_outside_msg", 1, 0);
        else end_msg();
        in_msg = 1'b0;
      end
    end
  end

  task automatic send(input logic [4:0] c);
    int n;
    n = 0;
    @(negedge clk_in);
    data_in = c;
    data_valid_in = 1'b1;
    while (!ready_out && n < 1000) begin
      @(negedge clk_in);
      n++;
    end
    if (!ready_out) chk("ready_timeout", 0, 1);
    @(posedge clk_in);
    #1;
    data_valid_in = 1'b0;
    data_in = ~c;
    exp_q.push_back(c);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_out && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    if (!done_out) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk_in);
    chk("rst_ready", int'(ready_out), 0);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_env", int'(envelope_out), 0);
    chk("rst_sig", int'(signal_out), 0);
    chk("rst_done", int'(done_out), 0);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("ready_after_rst", int'(ready_out), 1);

    send(5'b10110);
    wait_done();
    send(5'b00000);
    wait_done();

    send(5'd25);
    repeat (45) @(negedge clk_in);
    data_in = 5'd3;
    data_valid_in = 1'b1;
    @(negedge clk_in);
    data_valid_in = 1'b0;
    wait_done();
    repeat (5) @(negedge clk_in);
    chk("no_second_msg_busy", int'(busy_out), 0);
    chk("no_second_msg_ready", int'(ready_out), 1);

    @(negedge clk_in);
    data_in = 5'd7;
    data_valid_in = 1'b1;
    @(posedge clk_in);
    exp_q.push_back(5'd7);
    exp_q.push_back(5'd7);
    @(negedge clk_in);
    wait_done();
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!busy_out && n < 10);
    chk("b2b_delay", n, 2);
    chk("b2b_env", int'(envelope_out), 1);
    data_valid_in = 1'b0;
    wait_done();

    send(5'd13);
    wait_done();

    send(5'd0);
    void'(exp_q.pop_back());
    repeat (94) @(negedge clk_in);
    chk("bit2_burst_env", int'(envelope_out), 1);
    #2;
    rst_in = 1'b0;
    #1;
    chk("abort_env", int'(envelope_out), 0);
    chk("abort_sig", int'(signal_out), 0);
    chk("abort_busy", int'(busy_out), 0);
    chk("abort_ready", int'(ready_out), 0);
    chk("abort_done", int'(done_out), 0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("abort_ready_after", int'(ready_out), 1);
    repeat (300) @(negedge clk_in);
    chk("abort_stays_idle", int'(busy_out), 0);

    chk("queue_empty", exp_q.size(), 0);
    chk("sig_without_env", sig_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
